// File: rtl/link_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : link_test_ctrl
// Description : Sequencer and BER checker for the PRBS -> grey_encode ->
//               pam_4_encode -> ISI_channel -> DFE chain. Owns the chain
//               reset and PRBS enable, buffers transmitted symbols in a
//               reference FIFO, slices DFE output voltages into PAM-4
//               symbols and compares them against the buffered reference
//               for a programmed run length.
// Optional    : `define LINK_TEST_LEVEL_ERR_EN adds err_by_level, one
//               saturating mismatch counter per reference symbol value.
// Ports       : clk, rstn (sync active-low)      - clock / reset
//               start, abort, test_len           - run control
//               ref_symbol, ref_symbol_valid     - transmitted symbols
//               rx_signal, rx_signal_valid       - DFE output voltages
//               chain_rstn, prbs_en              - chain control
//               busy, done                       - run status
//               symbol_count, error_count        - run results
//               overflow                         - sticky FIFO fault
//               err_by_level (optional)          - per-level mismatches
// Revision    : 1.0 - initial release
// ============================================================================
module link_test_ctrl #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int RST_CYCLES        = 4,
  parameter int SETTLE_SYMBOLS    = 16,
  parameter int FIFO_DEPTH        = 16,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         abort,
  input  logic [CNT_WIDTH-1:0]         test_len,
  input  logic [1:0]                   ref_symbol,
  input  logic                         ref_symbol_valid,
  input  logic [SIGNAL_RESOLUTION-1:0] rx_signal,
  input  logic                         rx_signal_valid,
  output logic                         chain_rstn,
  output logic                         prbs_en,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_WIDTH-1:0]         symbol_count,
  output logic [CNT_WIDTH-1:0]         error_count,
`ifdef LINK_TEST_LEVEL_ERR_EN
  output logic [4*CNT_WIDTH-1:0]       err_by_level,
`endif
  output logic                         overflow
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_RESET_CHAIN = 3'd1,
    S_FILL        = 3'd2,
    S_MEASURE     = 3'd3,
    S_DONE        = 3'd4
  } state_t;

  localparam int c_AW  = $clog2(FIFO_DEPTH);
  localparam int c_MID = 1 << (SIGNAL_RESOLUTION - 1);

  localparam logic [SIGNAL_RESOLUTION-1:0] c_T0 = SIGNAL_RESOLUTION'(c_MID - SYMBOL_SEPERATION);
  localparam logic [SIGNAL_RESOLUTION-1:0] c_T1 = SIGNAL_RESOLUTION'(c_MID);
  localparam logic [SIGNAL_RESOLUTION-1:0] c_T2 = SIGNAL_RESOLUTION'(c_MID + SYMBOL_SEPERATION);

  localparam logic [CNT_WIDTH-1:0] c_RST_LAST = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_SETTLE   = CNT_WIDTH'(SETTLE_SYMBOLS);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 chain_rstn_q, prbs_en_q, busy_q, done_q;
`ifdef LINK_TEST_LEVEL_ERR_EN
  logic [CNT_WIDTH-1:0] lvl_q [4];
  logic [CNT_WIDTH-1:0] lvl_d [4];
`endif

  // Reference FIFO: pointers carry one extra bit to tell full from empty.
  logic [1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [c_AW:0] wr_ptr_q, rd_ptr_q;

  logic       w_start_ok, w_fifo_clr;
  logic       w_push_req, w_pop_req, w_full, w_empty;
  logic       w_push, w_pop, w_push_drop, w_pop_empty;
  logic [1:0] w_decision, w_ref;
  logic       w_mismatch;

  assign w_start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_fifo_clr = abort || w_start_ok;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                   (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);

  // FIFO traffic is suppressed in the cycle it is being cleared.
  assign w_push_req = ref_symbol_valid && chain_rstn_q && !w_fifo_clr;
  assign w_pop_req  = rx_signal_valid && !w_fifo_clr &&
                      ((state_q == S_FILL) || (state_q == S_MEASURE));

  assign w_pop       = w_pop_req && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_push_drop = w_push_req && w_full && !w_pop;
  assign w_pop_empty = w_pop_req && w_empty;

  assign w_ref = fifo_mem_q[rd_ptr_q[c_AW-1:0]];

  // PAM-4 slicer, unsigned thresholds centred on mid-scale.
  always_comb begin
    w_decision = 2'd3;
    if (rx_signal < c_T0) begin
      w_decision = 2'd0;
    end else if (rx_signal < c_T1) begin
      w_decision = 2'd1;
    end else if (rx_signal < c_T2) begin
      w_decision = 2'd2;
    end
  end

  assign w_mismatch = (w_decision != w_ref);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    settle_cnt_d = settle_cnt_q;
    len_d        = len_q;
    sym_cnt_d    = sym_cnt_q;
    err_cnt_d    = err_cnt_q;
    ovf_d        = ovf_q;
`ifdef LINK_TEST_LEVEL_ERR_EN
    lvl_d        = lvl_q;
`endif

    if (abort) begin
      state_d = S_IDLE;
    end else if (w_start_ok) begin
      state_d      = S_RESET_CHAIN;
      len_d        = test_len;
      rst_cnt_d    = '0;
      settle_cnt_d = '0;
      sym_cnt_d    = '0;
      err_cnt_d    = '0;
      ovf_d        = 1'b0;
`ifdef LINK_TEST_LEVEL_ERR_EN
      for (int k = 0; k < 4; k++) begin
        lvl_d[k] = '0;
      end
`endif
    end else begin
      if (w_push_drop || w_pop_empty) begin
        ovf_d = 1'b1;
      end

      case (state_q)
        S_RESET_CHAIN: begin
          if (rst_cnt_q == c_RST_LAST) begin
            state_d = S_FILL;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end

        S_FILL: begin
          // Already at the settle target (only when it is zero): leave
          // without waiting for a pop.
          if (settle_cnt_q == c_SETTLE) begin
            state_d = S_MEASURE;
          end else if (w_pop) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
            if (settle_cnt_d == c_SETTLE) begin
              state_d = S_MEASURE;
            end
          end
        end

        S_MEASURE: begin
          // Leaving together with the final count keeps later pops from
          // being counted past the programmed length.
          if (sym_cnt_q == len_q) begin
            state_d = S_DONE;
          end else if (w_pop) begin
            sym_cnt_d = sym_cnt_q + 1'b1;
            if (w_mismatch) begin
              if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
              end
`ifdef LINK_TEST_LEVEL_ERR_EN
              if (lvl_q[w_ref] != '1) begin
                lvl_d[w_ref] = lvl_q[w_ref] + 1'b1;
              end
`endif
            end
            if (sym_cnt_d == len_q) begin
              state_d = S_DONE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      settle_cnt_q <= '0;
      len_q        <= '0;
      sym_cnt_q    <= '0;
      err_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      chain_rstn_q <= 1'b0;
      prbs_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
`ifdef LINK_TEST_LEVEL_ERR_EN
      for (int k = 0; k < 4; k++) begin
        lvl_q[k] <= '0;
      end
`endif
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      len_q        <= len_d;
      sym_cnt_q    <= sym_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ovf_q        <= ovf_d;
      // Status outputs decoded from the next state so they line up with it.
      chain_rstn_q <= (state_d == S_FILL) || (state_d == S_MEASURE) || (state_d == S_DONE);
      prbs_en_q    <= (state_d == S_FILL) || (state_d == S_MEASURE);
      busy_q       <= (state_d == S_RESET_CHAIN) || (state_d == S_FILL) || (state_d == S_MEASURE);
      done_q       <= (state_d == S_DONE);
`ifdef LINK_TEST_LEVEL_ERR_EN
      lvl_q        <= lvl_d;
`endif
      if (w_fifo_clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (w_push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q[c_AW-1:0]] <= ref_symbol;
    end
  end

  assign chain_rstn   = chain_rstn_q;
  assign prbs_en      = prbs_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign symbol_count = sym_cnt_q;
  assign error_count  = err_cnt_q;
  assign overflow     = ovf_q;

`ifdef LINK_TEST_LEVEL_ERR_EN
  for (genvar k = 0; k < 4; k++) begin : g_lvl_out
    assign err_by_level[k*CNT_WIDTH +: CNT_WIDTH] = lvl_q[k];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_test_ctrl
// Description : Self-checking bench for link_test_ctrl. Drives reference
//               symbols and receive voltages directly and predicts the
//               counters from a queue model of the symbol stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_test_ctrl;

  localparam int SR     = 8;
  localparam int SEP    = 56;
  localparam int RSTC   = 4;
  localparam int SETTLE = 16;
  localparam int DEPTH  = 16;
  localparam int CW     = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [CW-1:0] test_len;
  logic [1:0]    ref_symbol;
  logic          ref_symbol_valid;
  logic [SR-1:0] rx_signal;
  logic          rx_signal_valid;
  logic          chain_rstn;
  logic          prbs_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] symbol_count;
  logic [CW-1:0] error_count;
  logic          overflow;
`ifdef LINK_TEST_LEVEL_ERR_EN
  logic [4*CW-1:0] err_by_level;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int bref [6] = '{0, 1, 1, 2, 2, 3};
  int bv   [6] = '{71, 72, 127, 128, 183, 184};

  always #5 clk = ~clk;

  link_test_ctrl #(
    .SIGNAL_RESOLUTION (SR),
    .SYMBOL_SEPERATION (SEP),
    .RST_CYCLES        (RSTC),
    .SETTLE_SYMBOLS    (SETTLE),
    .FIFO_DEPTH        (DEPTH),
    .CNT_WIDTH         (CW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .abort            (abort),
    .test_len         (test_len),
    .ref_symbol       (ref_symbol),
    .ref_symbol_valid (ref_symbol_valid),
    .rx_signal        (rx_signal),
    .rx_signal_valid  (rx_signal_valid),
    .chain_rstn       (chain_rstn),
    .prbs_en          (prbs_en),
    .busy             (busy),
    .done             (done),
    .symbol_count     (symbol_count),
    .error_count      (error_count),
`ifdef LINK_TEST_LEVEL_ERR_EN
    .err_by_level     (err_by_level),
`endif
    .overflow         (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Symbol decision: how many of the three thresholds the voltage reaches.
  function automatic int slice(input int v);
    int mid;
    mid = 1 << (SR - 1);
    return ((v >= mid - SEP) ? 1 : 0) + ((v >= mid) ? 1 : 0) + ((v >= mid + SEP) ? 1 : 0);
  endfunction

  // Ideal PAM-4 level for a symbol: mid-scale +/- 0.5 and 1.5 spacings.
  function automatic int level_v(input int s);
    return (1 << (SR - 1)) + ((2 * s - 3) * SEP) / 2;
  endfunction

  task automatic wait_chain(input string tag);
    for (int i = 0; i < 50 && !chain_rstn; i++) tick();
    chk({tag, "_chain_up"}, 64'(chain_rstn), 64'(1));
  endtask

  // mode 0: clean random, 1: noisy random, 2: constant 130 vs 0/3 refs,
  // 3: slicer boundary voltages with matching refs
  task automatic run(input int len, input int mode, input int abort_at,
                     input bit start_in_fill, input string tag);
    int q[$];
    int pops, pushes, exp_sym, exp_err, low_cycles, cyc, v, s, r;
    int exp_lvl[4];
    bit do_pop, do_push, sif;
    pops = 0; pushes = 0; exp_sym = 0; exp_err = 0; sif = 0;
    for (int k = 0; k < 4; k++) exp_lvl[k] = 0;

    start = 1'b1;
    test_len = CW'(len);
    tick();
    start = 1'b0;
    chk({tag, "_busy_at_start"}, 64'(busy), 64'(1));
    chk({tag, "_cnt_cleared"}, 64'(symbol_count), 64'(0));
    chk({tag, "_err_cleared"}, 64'(error_count), 64'(0));
    chk({tag, "_ovf_cleared"}, 64'(overflow), 64'(0));

    low_cycles = chain_rstn ? 0 : 1;
    for (int i = 0; i < 50 && !chain_rstn; i++) begin
      tick();
      if (!chain_rstn) low_cycles++;
    end
    chk({tag, "_rst_cycles"}, 64'(low_cycles), 64'(RSTC));
    chk({tag, "_prbs_en"}, 64'(prbs_en), 64'(1));

    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (abort_at >= 0 && symbol_count == CW'(abort_at)) begin
        abort = 1'b1;
        ref_symbol_valid = 1'b0;
        rx_signal_valid = 1'b0;
        tick();
        abort = 1'b0;
        chk({tag, "_abort_busy"}, 64'(busy), 64'(0));
        chk({tag, "_abort_chain"}, 64'(chain_rstn), 64'(0));
        chk({tag, "_abort_prbs"}, 64'(prbs_en), 64'(0));
        chk({tag, "_abort_cnt"}, 64'(symbol_count), 64'(exp_sym));
        chk({tag, "_abort_err"}, 64'(error_count), 64'(exp_err));
        return;
      end
      if (start_in_fill && !sif && pops == 3) begin
        start = 1'b1;
        test_len = CW'(5);
        sif = 1'b1;
      end
      do_pop  = (q.size() > 0) && ($urandom_range(9) < 8);
      do_push = ((q.size() < DEPTH) || do_pop) && ($urandom_range(9) < 7);

      case (mode)
        2:       s = (pushes % 2 == 1) ? 3 : 0;
        3:       s = bref[pushes % 6];
        default: s = int'($urandom_range(3));
      endcase
      ref_symbol_valid = do_push;
      ref_symbol = 2'(s);

      rx_signal_valid = do_pop;
      v = 0;
      if (do_pop) begin
        r = q.pop_front();
        case (mode)
          1: v = ($urandom_range(3) == 0) ? int'($urandom_range(255))
                                          : level_v(r) + int'($urandom_range(54)) - 27;
          2: v = 130;
          3: v = bv[pops % 6];
          default: v = level_v(r) + int'($urandom_range(54)) - 27;
        endcase
        if (pops >= SETTLE && pops < SETTLE + len) begin
          exp_sym++;
          if (slice(v) != r) begin
            exp_err++;
            exp_lvl[r]++;
          end
        end
        pops++;
      end
      rx_signal = SR'(v);
      if (do_push) begin
        q.push_back(s);
        pushes++;
      end
      tick();
      start = 1'b0;
    end
    ref_symbol_valid = 1'b0;
    rx_signal_valid = 1'b0;

    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_prbs_off"}, 64'(prbs_en), 64'(0));
    chk({tag, "_chain_held"}, 64'(chain_rstn), 64'(1));
    chk({tag, "_symbols"}, 64'(symbol_count), 64'(exp_sym));
    chk({tag, "_errors"}, 64'(error_count), 64'(exp_err));
    chk({tag, "_overflow"}, 64'(overflow), 64'(0));
`ifdef LINK_TEST_LEVEL_ERR_EN
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_lvl%0d", tag, k), 64'(err_by_level[k*CW +: CW]), 64'(exp_lvl[k]));
`endif
    tick();
    chk({tag, "_hold_symbols"}, 64'(symbol_count), 64'(exp_sym));
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    test_len = '0;
    ref_symbol = 2'd0;
    ref_symbol_valid = 1'b0;
    rx_signal = '0;
    rx_signal_valid = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    chk("rst_chain", 64'(chain_rstn), 64'(0));
    chk("rst_prbs", 64'(prbs_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_symbols", 64'(symbol_count), 64'(0));
    chk("rst_errors", 64'(error_count), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
`ifdef LINK_TEST_LEVEL_ERR_EN
    chk("rst_lvl", 64'(err_by_level != '0), 64'(0));
`endif

    run(100, 0, -1, 1'b0, "clean");
    chk("clean_len", 64'(symbol_count), 64'(100));
    run(10, 2, -1, 1'b0, "const130");
    chk("const130_err", 64'(error_count), 64'(10));
    run(12, 3, -1, 1'b0, "bounds");
    run(60, 1, -1, 1'b0, "noisy");

    // Reference FIFO overflow: pushes with no receive samples.
    start = 1'b1;
    test_len = CW'(50);
    tick();
    start = 1'b0;
    wait_chain("ovf");
    for (int i = 0; i < DEPTH; i++) begin
      ref_symbol_valid = 1'b1;
      ref_symbol = 2'($urandom_range(3));
      tick();
    end
    chk("ovf_full_no_flag", 64'(overflow), 64'(0));
    tick();
    ref_symbol_valid = 1'b0;
    chk("ovf_flag", 64'(overflow), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ovf_abort_idle", 64'(busy), 64'(0));

    // Underflow: receive sample with nothing buffered.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("udf_cleared", 64'(overflow), 64'(0));
    wait_chain("udf");
    rx_signal_valid = 1'b1;
    rx_signal = SR'(100);
    tick();
    rx_signal_valid = 1'b0;
    chk("udf_flag", 64'(overflow), 64'(1));
    chk("udf_symbols", 64'(symbol_count), 64'(0));
    abort = 1'b1;
    tick();
    abort = 1'b0;

    run(100, 0, 40, 1'b0, "abort");
    chk("abort_idle_done", 64'(done), 64'(0));
    run(20, 0, -1, 1'b0, "after_abort");
    run(0, 0, -1, 1'b0, "len0");
    run(30, 0, -1, 1'b1, "start_in_fill");
    chk("sif_len", 64'(symbol_count), 64'(30));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/link_test_ctrl.md
Name: link_test_ctrl

Overview:
Sequencer and BER checker for the PRBS -> grey_encode -> pam_4_encode -> ISI_channel -> DFE chain. It owns the chain reset and PRBS enable, and buffers transmitted symbols in a reference FIFO. It slices DFE output voltages into symbols and compares them against the delayed reference. It counts compared symbols and errors for a programmed run length, then reports done.

Parameters:
SIGNAL_RESOLUTION, 8, width of DFE voltage input.
SYMBOL_SEPERATION, 56, PAM-4 level spacing; sets slicer thresholds.
RST_CYCLES, 4, cycles chain_rstn is held low at run start (>=1).
SETTLE_SYMBOLS, 16, rx-valid symbols discarded before measurement (>=0).
FIFO_DEPTH, 16, reference symbol FIFO depth, power of 2.
CNT_WIDTH, 32, width of length and counters.

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a run when IDLE or DONE
abort  in  1  return to IDLE, drop chain_rstn and prbs_en
test_len  in  CNT_WIDTH  symbols to compare; sampled on accepted start
ref_symbol  in  2  grey_encode symbol_out
ref_symbol_valid  in  1  grey_encode symbol_out_valid
rx_signal  in  SIGNAL_RESOLUTION  DFE signal_out
rx_signal_valid  in  1  DFE signal_out_valid
chain_rstn  out  1  sync active-low reset driven to all chain blocks
prbs_en  out  1  PRBS enable
busy  out  1  high in RESET_CHAIN/FILL/MEASURE
done  out  1  level, high in DONE
symbol_count  out  CNT_WIDTH  symbols compared this run
error_count  out  CNT_WIDTH  mismatches this run, saturating
overflow  out  1  sticky; reference FIFO overflowed or underflowed

Behaviour:
- Reset (rstn=0 at clk edge): state IDLE. chain_rstn=0, prbs_en=0, busy=0, done=0. Counters=0, overflow=0, FIFO empty.
- IDLE: start -> RESET_CHAIN. Latch test_len, clear counters, overflow and FIFO.
- RESET_CHAIN: chain_rstn=0 for exactly RST_CYCLES cycles, then FILL. prbs_en=1 and chain_rstn=1 from the first FILL cycle.
- FIFO: push ref_symbol on every ref_symbol_valid while chain_rstn=1. Pop on every rx_signal_valid in FILL/MEASURE. Push and pop in the same cycle are legal, including when full. Push while full and not popping: data dropped, overflow=1. rx_signal_valid while empty: overflow=1, no compare.
- Slicer: MID=2^(SIGNAL_RESOLUTION-1). Thresholds T0=MID-SEP, T1=MID, T2=MID+SEP, unsigned compare. Decision: v<T0 -> 0; v<T1 -> 1; v<T2 -> 2; else 3. Defaults give thresholds 72/128/184.
- FILL: each popped pair is discarded. After SETTLE_SYMBOLS pops -> MEASURE. SETTLE_SYMBOLS=0 goes to MEASURE on the next cycle.
- MEASURE: each popped pair increments symbol_count. Slicer decision != popped ref increments error_count, saturating at all-ones. When symbol_count reaches latched test_len -> DONE on the next cycle.
- test_len=0: MEASURE exits immediately to DONE with zero counts.
- DONE: prbs_en=0, chain_rstn stays 1, counters hold. start restarts as from IDLE.
- start while busy: ignored.
- abort: has priority over start and all transitions. Next state IDLE, chain_rstn=0, prbs_en=0, counters hold, FIFO cleared.
- Outputs are registered; state change is visible one cycle after the triggering edge.

Optional Feature:
LINK_TEST_LEVEL_ERR_EN: when defined, adds output err_by_level (4*CNT_WIDTH). It holds one saturating counter per reference symbol value, counting mismatches where ref equals that value. The counters are cleared on start and hold in DONE. When undefined, the port and counters are absent and all other behaviour is identical.

Test Plan:
- Reset, then start with test_len=100 on the clean chain (ISI + DFE default) -> chain_rstn low 4 cycles, 16 settle pops, done=1, symbol_count=100, error_count=0, overflow=0.
- Force rx_signal to constant 130 with a ref stream of alternating 0/3 and test_len=10 -> every sample slices to 2, so error_count=10. With LINK_TEST_LEVEL_ERR_EN: err_by_level[0]=5, [3]=5.
- Slicer boundaries: rx values 71, 72, 127, 128, 183, 184 -> decisions 0, 1, 1, 2, 2, 3 respectively, checked against matching refs with zero errors.
- Drive 17 ref pushes with no rx_signal_valid (FIFO_DEPTH=16) -> overflow=1. Separately, an rx valid on an empty FIFO -> overflow=1 and symbol_count unchanged.
- Assert abort mid-MEASURE at symbol 40 -> IDLE next cycle, chain_rstn=0, prbs_en=0, symbol_count holds 40. A subsequent start clears the counters and runs normally.
- start with test_len=0 -> done after settle with counts 0. Pulse start during FILL -> ignored, and the run completes with the original test_len.
